// File: rtl/brecv_pkg.sv
// Shared definitions for the receive side of the 4-phase req/ack CDC handshake.
//   - receive FSM state encoding (2 bits: IDLE, VALID, ACK; encoding 3 unused)
//   - legal range for the areq synchroniser depth
package brecv_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] VALID = 2'd1;
  localparam logic [STATE_W-1:0] ACK   = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = IDLE,
    ST_VALID = VALID,
    ST_ACK   = ACK
  } state_t;

  // Fewer than two flops gives no metastability margin. More than three only adds latency.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

endpackage

// File: rtl/brecv_if.sv
// Bundles the handshake signals of the receive FSM.
//   areq/adata : request level and data word from the source domain
//   back       : acknowledge level returned to the source domain
//   bdata/bvalid/bready : downstream valid/ready word interface
//   bbusy      : receiver is not idle
// Modports:
//   master : source + downstream side (drives areq, adata, bready)
//   slave  : the receive FSM (drives back, bdata, bvalid, bbusy)
interface brecv_if #(
  parameter int DW = 8
);
  logic          areq;
  logic [DW-1:0] adata;
  logic          back;
  logic [DW-1:0] bdata;
  logic          bvalid;
  logic          bready;
  logic          bbusy;

  modport master (
    output areq, adata, bready,
    input  back, bdata, bvalid, bbusy
  );

  modport slave (
    input  areq, adata, bready,
    output back, bdata, bvalid, bbusy
  );
endinterface

// File: rtl/bit_sync.sv
// Single-bit level synchroniser. It is a STAGES-deep flop chain in the clk domain.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset; clears every stage
//   i_d : asynchronous input level
//   o_q : synchronised level (last stage of the chain)
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/brecv_fsm.sv
// Destination-domain receive FSM of the 4-phase req/ack handshake.
// areq is synchronised into bclk. On a new request adata is captured and offered
// downstream with valid/ready. Once downstream accepts the word, back is raised. It is
// held high until the synchronised request drops. Each 4-phase cycle delivers one word.
// Ports:
//   bclk : destination clock (only clock of this block)
//   brst : synchronous active-high reset
//   bus  : brecv_if slave modport
//          in : areq, adata, bready
//          out: back, bdata, bvalid, bbusy (all straight from flops)
module brecv_fsm
  import brecv_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic     bclk,
  input  logic     brst,
  brecv_if.slave   bus
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("brecv_fsm: SYNC_STAGES must be 2 or 3");
  end

  logic          w_req_s;
  state_t        r_state;
  logic          r_back;
  logic          r_bvalid;
  logic          r_bbusy;
  logic [DW-1:0] r_bdata;

  // areq is only ever observed through this synchroniser.
  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (bclk),
    .rst (brst),
    .i_d (bus.areq),
    .o_q (w_req_s)
  );

  always_ff @(posedge bclk) begin
    if (brst) begin
      r_state  <= ST_IDLE;
      r_back   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bbusy  <= 1'b0;
      r_bdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // adata is guaranteed stable once the request is visible here.
          if (w_req_s) begin
            r_bdata  <= bus.adata;
            r_bvalid <= 1'b1;
            r_bbusy  <= 1'b1;
            r_state  <= ST_VALID;
          end
        end
        ST_VALID: begin
          // A request that drops early is ignored here. It is handled in ACK.
          if (r_bvalid && bus.bready) begin
            r_bvalid <= 1'b0;
            r_back   <= 1'b1;
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          // A new capture requires req_s to go low first, so a held-high request is not re-captured.
          if (!w_req_s) begin
            r_back  <= 1'b0;
            r_bbusy <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_back   <= 1'b0;
          r_bvalid <= 1'b0;
          r_bbusy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.back   = r_back;
  assign bus.bvalid = r_bvalid;
  assign bus.bbusy  = r_bbusy;
  assign bus.bdata  = r_bdata;

endmodule

// File: tb/tb_brecv_fsm.sv
module tb_brecv_fsm;

  logic       clk;
  logic       brst;
  logic       areq;
  logic [7:0] adata;
  logic       bready;

  int n_cmp;
  int n_bad;

  brecv_if #(.DW(8)) bus2 ();
  brecv_if #(.DW(8)) bus3 ();

  assign bus2.areq   = areq;
  assign bus2.adata  = adata;
  assign bus2.bready = bready;
  assign bus3.areq   = areq;
  assign bus3.adata  = adata;
  assign bus3.bready = bready;

  brecv_fsm #(.DW(8), .SYNC_STAGES(2)) dut2 (
    .bclk (clk),
    .brst (brst),
    .bus  (bus2.slave)
  );

  brecv_fsm #(.DW(8), .SYNC_STAGES(3)) dut3 (
    .bclk (clk),
    .brst (brst),
    .bus  (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard of accepted words on the SYNC_STAGES=2 instance.
  logic [7:0] hs_q[$];
  always @(posedge clk) begin
    if (!brst && bus2.bvalid && bready) hs_q.push_back(bus2.bdata);
  end

  typedef struct {
    logic       areq;
    logic [7:0] adata;
    logic       bready;
    logic       exp_bvalid;
    logic [7:0] exp_bdata;
    logic       exp_back;
    logic       exp_bbusy;
  } vec_t;

  vec_t vecs[32];
  int   nvec;

  task automatic add(input logic a, input logic [7:0] d, input logic r,
                     input logic ev, input logic [7:0] ed, input logic eb, input logic ey);
    vecs[nvec] = '{areq: a, adata: d, bready: r, exp_bvalid: ev, exp_bdata: ed,
                   exp_back: eb, exp_bbusy: ey};
    nvec++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    brst   = 1'b1;
    areq   = 1'b0;
    adata  = 8'h00;
    bready = 1'b0;
    step();
    step();
    brst = 1'b0;
  endtask

  task automatic wait_back(input logic lvl, input string name);
    for (int k = 0; k < 50 && bus2.back !== lvl; k++) step();
    check(name, {31'd0, bus2.back}, {31'd0, lvl});
  endtask

  task automatic wait_bvalid(input string name);
    for (int k = 0; k < 50 && bus2.bvalid !== 1'b1; k++) step();
    check(name, {31'd0, bus2.bvalid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int back_hi;
    int extra_valid;
    int n;
    int first2;
    int first3;
    logic [7:0] d3;

    n_cmp = 0;
    n_bad = 0;
    nvec  = 0;

    // Reset state
    do_reset();
    check("rst.bvalid2", {31'd0, bus2.bvalid}, 32'd0);
    check("rst.back2",   {31'd0, bus2.back},   32'd0);
    check("rst.bbusy2",  {31'd0, bus2.bbusy},  32'd0);
    check("rst.bdata2",  {24'd0, bus2.bdata},  32'd0);
    check("rst.bvalid3", {31'd0, bus3.bvalid}, 32'd0);
    check("rst.bbusy3",  {31'd0, bus3.bbusy},  32'd0);

    // Scenario 1: basic transfer, then scenario 2: back-pressure.
    add(1, 8'hA5, 1,  0, 8'h00, 0, 0);
    add(1, 8'hA5, 1,  0, 8'h00, 0, 0);
    add(1, 8'hA5, 1,  1, 8'hA5, 0, 1);
    add(1, 8'hA5, 1,  0, 8'hA5, 1, 1);
    add(0, 8'hA5, 1,  0, 8'hA5, 1, 1);
    add(0, 8'hA5, 1,  0, 8'hA5, 1, 1);
    add(0, 8'hA5, 1,  0, 8'hA5, 0, 0);
    add(0, 8'hA5, 1,  0, 8'hA5, 0, 0);
    add(1, 8'h3C, 0,  0, 8'hA5, 0, 0);
    add(1, 8'h3C, 0,  0, 8'hA5, 0, 0);
    add(1, 8'h3C, 0,  1, 8'h3C, 0, 1);
    for (int i = 0; i < 10; i++) add(1, 8'h77, 0, 1, 8'h3C, 0, 1);
    add(1, 8'h77, 1,  0, 8'h3C, 1, 1);
    add(0, 8'h77, 1,  0, 8'h3C, 1, 1);
    add(0, 8'h77, 1,  0, 8'h3C, 1, 1);
    add(0, 8'h77, 1,  0, 8'h3C, 0, 0);

    hs_q.delete();
    for (int i = 0; i < nvec; i++) begin
      areq   = vecs[i].areq;
      adata  = vecs[i].adata;
      bready = vecs[i].bready;
      step();
      check($sformatf("vec%0d.bvalid", i), {31'd0, bus2.bvalid}, {31'd0, vecs[i].exp_bvalid});
      check($sformatf("vec%0d.bdata", i),  {24'd0, bus2.bdata},  {24'd0, vecs[i].exp_bdata});
      check($sformatf("vec%0d.back", i),   {31'd0, bus2.back},   {31'd0, vecs[i].exp_back});
      check($sformatf("vec%0d.bbusy", i),  {31'd0, bus2.bbusy},  {31'd0, vecs[i].exp_bbusy});
    end
    check("tbl.hs_count", hs_q.size(), 32'd2);
    $display("table: %0d vectors applied", nvec);

    // Scenario 3: areq held high after back rises -> no second capture.
    do_reset();
    hs_q.delete();
    areq = 1'b1; adata = 8'h5A; bready = 1'b1;
    wait_back(1'b1, "nodup.back_rise");
    back_hi = 0;
    extra_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus2.back === 1'b1) back_hi++;
      if (bus2.bvalid !== 1'b0) extra_valid++;
    end
    check("nodup.back_held", back_hi, 32'd20);
    check("nodup.no_revalid", extra_valid, 32'd0);
    check("nodup.hs_count", hs_q.size(), 32'd1);
    if (hs_q.size() > 0) check("nodup.word", {24'd0, hs_q[0]}, 32'h5A);
    areq = 1'b0;
    wait_back(1'b0, "nodup.back_fall");
    $display("nodup: back high %0d cycles, handshakes %0d", back_hi, hs_q.size());

    // Scenario 4: four back-to-back full 4-phase cycles.
    do_reset();
    hs_q.delete();
    bready = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      areq  = 1'b1;
      adata = 8'(w);
      wait_back(1'b1, $sformatf("b2b%0d.back_rise", w));
      areq = 1'b0;
      wait_back(1'b0, $sformatf("b2b%0d.back_fall", w));
      $display("b2b: word %0d sent", w);
    end
    check("b2b.hs_count", hs_q.size(), 32'd4);
    for (int w = 0; w < 4 && w < hs_q.size(); w++)
      check($sformatf("b2b.word%0d", w), {24'd0, hs_q[w]}, w + 1);

    // areq drops while in VALID: ignored, transfer completes, straight through ACK to IDLE.
    do_reset();
    areq = 1'b1; adata = 8'h96; bready = 1'b0;
    wait_bvalid("viol.bvalid_rise");
    areq = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("viol.bvalid_held", {31'd0, bus2.bvalid}, 32'd1);
    check("viol.bdata_held",  {24'd0, bus2.bdata},  32'h96);
    check("viol.back_low",    {31'd0, bus2.back},   32'd0);
    bready = 1'b1;
    step();
    check("viol.back_rise", {31'd0, bus2.back}, 32'd1);
    step();
    check("viol.back_fall", {31'd0, bus2.back},  32'd0);
    check("viol.idle",      {31'd0, bus2.bbusy}, 32'd0);
    $display("viol: completed with early areq drop");

    // Scenario 5: reset in VALID with areq still high.
    do_reset();
    areq = 1'b1; adata = 8'hC3; bready = 1'b0;
    wait_bvalid("rstmid.bvalid_rise");
    brst = 1'b1;
    step();
    check("rstmid.bvalid", {31'd0, bus2.bvalid}, 32'd0);
    check("rstmid.back",   {31'd0, bus2.back},   32'd0);
    check("rstmid.bbusy",  {31'd0, bus2.bbusy},  32'd0);
    brst = 1'b0;
    n = 0;
    for (int k = 0; k < 10 && bus2.bvalid !== 1'b1; k++) begin
      step();
      n++;
    end
    check("rstmid.recapture_edges", n, 32'd3);
    check("rstmid.bdata", {24'd0, bus2.bdata}, 32'hC3);
    $display("rstmid: recaptured after %0d edges", n);

    // Scenario 6: SYNC_STAGES=3 is one edge slower than SYNC_STAGES=2.
    do_reset();
    areq = 1'b1; adata = 8'hA5; bready = 1'b1;
    first2 = 0;
    first3 = 0;
    d3 = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (first2 == 0 && bus2.bvalid === 1'b1) first2 = k;
      if (first3 == 0 && bus3.bvalid === 1'b1) begin
        first3 = k;
        d3 = bus3.bdata;
      end
    end
    check("sync2.latency", first2, 32'd3);
    check("sync3.latency", first3, 32'd4);
    check("sync3.bdata", {24'd0, d3}, 32'hA5);
    $display("sync: bvalid at edge %0d (2 stages), %0d (3 stages)", first2, first3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
